// File: rtl/multicycle_control_if.sv
// -----------------------------------------------------------------------------
// multicycle_control_if
//
// Bundle of the signals between the multicycle controller and its datapath.
//
//   op            6  opcode from the instruction register
//   memReady      1  memory completes the current access this cycle
//   memRead       1  memory read strobe
//   memWrite      1  memory write strobe
//   iorD          1  memory address select (1 = ALUOut, 0 = PC)
//   irWrite       1  instruction register load
//   pcWrite       1  unconditional PC load
//   pcWriteCond   1  PC load qualified by the ALU zero flag
//   pcSrc         2  PC source: 00 ALU result, 01 ALUOut, 10 jump target
//   aluSrcA       1  ALU A operand: 0 PC, 1 register A
//   aluSrcB       2  ALU B operand: 00 reg B, 01 const 4, 10 sext imm, 11 shifted imm
//   aluOP         2  00 add, 01 subtract, 10 funct-decoded
//   regDst        1  register-file destination select
//   memToReg      1  register-file write-data select
//   regWrite      1  register-file write enable
//   illegalOp     1  one-cycle pulse on an undecodable opcode
//   busErr        1  one-cycle pulse on a memory access timeout
//   state         4  current controller state, for debug
//
// Modports: master = controller side, slave = datapath side.
// -----------------------------------------------------------------------------
interface multicycle_control_if;
  logic [5:0] op;
  logic       memReady;
  logic       memRead;
  logic       memWrite;
  logic       iorD;
  logic       irWrite;
  logic       pcWrite;
  logic       pcWriteCond;
  logic [1:0] pcSrc;
  logic       aluSrcA;
  logic [1:0] aluSrcB;
  logic [1:0] aluOP;
  logic       regDst;
  logic       memToReg;
  logic       regWrite;
  logic       illegalOp;
  logic       busErr;
  logic [3:0] state;

  modport master (
    input  op, memReady,
    output memRead, memWrite, iorD, irWrite, pcWrite, pcWriteCond, pcSrc,
           aluSrcA, aluSrcB, aluOP, regDst, memToReg, regWrite,
           illegalOp, busErr, state
  );

  modport slave (
    output op, memReady,
    input  memRead, memWrite, iorD, irWrite, pcWrite, pcWriteCond, pcSrc,
           aluSrcA, aluSrcB, aluOP, regDst, memToReg, regWrite,
           illegalOp, busErr, state
  );
endinterface

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//
// Main control FSM of a multicycle MIPS-style processor. Sequences instruction
// fetch, decode and the per-class execute steps, and guards every memory access
// with a wait-cycle timeout that diverts to a one-cycle bus-error state.
//
// Ports:
//   clk     sole clock, rising edge
//   reset   synchronous, active-high; forces FETCH and clears the wait counter
//   bus     multicycle_control_if.master (opcode, memReady, all control outputs)
//
// Parameters:
//   TIMEOUT_CYC  consecutive memReady-low cycles tolerated per access (1..255)
//   CNT_W        wait counter width, 2**CNT_W must exceed TIMEOUT_CYC
//
// Build option:
//   MULTICYCLE_CONTROL_ADDI_EN  when defined, opcode 001000 (addi) executes via
//                               ADDIEX/ADDIWB; otherwise it is an illegal opcode.
//
// state   | meaning
// --------+-----------------------------------------------------------
// FETCH   | read instruction at PC, PC+4; waits on memReady
// DECODE  | register read, branch target calc, opcode dispatch
// MEMADR  | effective address for lw/sw
// MEMRD   | data read at ALUOut; waits on memReady
// MEMWB   | load data written to register file
// MEMWR   | data write at ALUOut; waits on memReady
// EXEC    | R-type ALU operation
// RWB     | R-type result written to register file
// BRANCH  | beq compare, conditional PC load
// JUMP    | PC load from jump target
// ADDIEX  | addi ALU operation (optional)
// ADDIWB  | addi result written to register file (optional)
// ILLEGAL | one-cycle illegalOp pulse
// BUSERR  | one-cycle busErr pulse after a memory timeout
// -----------------------------------------------------------------------------
module multicycle_control #(
  parameter int TIMEOUT_CYC = 15,
  parameter int CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXEC    = 4'd6,
    RWB     = 4'd7,
    BRANCH  = 4'd8,
    JUMP    = 4'd9,
`ifdef MULTICYCLE_CONTROL_ADDI_EN
    ADDIEX  = 4'd10,
    ADDIWB  = 4'd11,
`endif
    ILLEGAL = 4'd12,
    BUSERR  = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MULTICYCLE_CONTROL_ADDI_EN
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

  // Counter value seen during the last tolerated wait cycle of an access.
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] wait_cnt;
  logic             in_wait;
  logic             timeout;

  assign in_wait = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);

  // memReady takes priority: a ready in the last tolerated cycle completes
  // the access, so the timeout term only looks at the not-ready case.
  assign timeout = in_wait && !bus.memReady && (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= FETCH;
      wait_cnt <= '0;
    end else begin
      state_q <= state_d;
      // Any state change clears the counter, which covers every entry into a
      // wait state; holding in a wait state with memReady low counts up.
      if (state_d != state_q) begin
        wait_cnt <= '0;
      end else if (in_wait && !bus.memReady) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH: begin
        if (bus.memReady)  state_d = DECODE;
        else if (timeout)  state_d = BUSERR;
      end
      DECODE: begin
        case (bus.op)
          OP_RTYPE:     state_d = EXEC;
          OP_LW, OP_SW: state_d = MEMADR;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
`ifdef MULTICYCLE_CONTROL_ADDI_EN
          OP_ADDI:      state_d = ADDIEX;
`endif
          default:      state_d = ILLEGAL;
        endcase
      end
      MEMADR: begin
        if (bus.op == OP_LW) state_d = MEMRD;
        else                 state_d = MEMWR;
      end
      MEMRD: begin
        if (bus.memReady)  state_d = MEMWB;
        else if (timeout)  state_d = BUSERR;
      end
      MEMWB:   state_d = FETCH;
      MEMWR: begin
        if (bus.memReady)  state_d = FETCH;
        else if (timeout)  state_d = BUSERR;
      end
      EXEC:    state_d = RWB;
      RWB:     state_d = FETCH;
      BRANCH:  state_d = FETCH;
      JUMP:    state_d = FETCH;
`ifdef MULTICYCLE_CONTROL_ADDI_EN
      ADDIEX:  state_d = ADDIWB;
      ADDIWB:  state_d = FETCH;
`endif
      ILLEGAL: state_d = FETCH;
      BUSERR:  state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  // Control outputs. Only the fetch IR/PC loads look at memReady, so a
  // timed-out fetch never loads IR or PC.
  always_comb begin
    bus.memRead     = 1'b0;
    bus.memWrite    = 1'b0;
    bus.iorD        = 1'b0;
    bus.irWrite     = 1'b0;
    bus.pcWrite     = 1'b0;
    bus.pcWriteCond = 1'b0;
    bus.pcSrc       = 2'b00;
    bus.aluSrcA     = 1'b0;
    bus.aluSrcB     = 2'b00;
    bus.aluOP       = 2'b00;
    bus.regDst      = 1'b0;
    bus.memToReg    = 1'b0;
    bus.regWrite    = 1'b0;
    bus.illegalOp   = 1'b0;
    bus.busErr      = 1'b0;
    case (state_q)
      FETCH: begin
        bus.memRead = 1'b1;
        bus.aluSrcB = 2'b01;
        bus.irWrite = bus.memReady;
        bus.pcWrite = bus.memReady;
      end
      DECODE: begin
        bus.aluSrcB = 2'b11;
      end
      MEMADR: begin
        bus.aluSrcA = 1'b1;
        bus.aluSrcB = 2'b10;
      end
      MEMRD: begin
        bus.memRead = 1'b1;
        bus.iorD    = 1'b1;
      end
      MEMWB: begin
        bus.regWrite = 1'b1;
        bus.memToReg = 1'b1;
      end
      MEMWR: begin
        bus.memWrite = 1'b1;
        bus.iorD     = 1'b1;
      end
      EXEC: begin
        bus.aluSrcA = 1'b1;
        bus.aluOP   = 2'b10;
      end
      RWB: begin
        bus.regDst   = 1'b1;
        bus.regWrite = 1'b1;
      end
      BRANCH: begin
        bus.aluSrcA     = 1'b1;
        bus.aluOP       = 2'b01;
        bus.pcWriteCond = 1'b1;
        bus.pcSrc       = 2'b01;
      end
      JUMP: begin
        bus.pcWrite = 1'b1;
        bus.pcSrc   = 2'b10;
      end
`ifdef MULTICYCLE_CONTROL_ADDI_EN
      ADDIEX: begin
        bus.aluSrcA = 1'b1;
        bus.aluSrcB = 2'b10;
        bus.aluOP   = 2'b00;
      end
      ADDIWB: begin
        bus.regWrite = 1'b1;
      end
`endif
      ILLEGAL: begin
        bus.illegalOp = 1'b1;
      end
      BUSERR: begin
        bus.busErr = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
//
// Two controller instances run side by side: u_dut0 with the default timeout
// (15) and u_dut1 with TIMEOUT_CYC=3, CNT_W=2. A behavioural model tracks each
// instance's state and the number of wait cycles of the current access; state
// and all control outputs are compared every cycle, followed by directed
// scenario checks and a randomized phase.
// -----------------------------------------------------------------------------
module tb_multicycle_control;

  typedef struct packed {
    logic       memRead;
    logic       memWrite;
    logic       iorD;
    logic       irWrite;
    logic       pcWrite;
    logic       pcWriteCond;
    logic [1:0] pcSrc;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOP;
    logic       regDst;
    logic       memToReg;
    logic       regWrite;
    logic       illegalOp;
    logic       busErr;
  } ctrl_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b0;
  logic [5:0] op_d  [2];
  logic       rdy_d [2];

  multicycle_control_if bus0 ();
  multicycle_control_if bus1 ();

  assign bus0.op       = op_d[0];
  assign bus0.memReady = rdy_d[0];
  assign bus1.op       = op_d[1];
  assign bus1.memReady = rdy_d[1];

  multicycle_control u_dut0 (
    .clk   (clk),
    .reset (rst),
    .bus   (bus0)
  );

  multicycle_control #(.TIMEOUT_CYC(3), .CNT_W(2)) u_dut1 (
    .clk   (clk),
    .reset (rst),
    .bus   (bus1)
  );

  ctrl_t      obs    [2];
  logic [3:0] st_obs [2];

  assign obs[0] = {bus0.memRead, bus0.memWrite, bus0.iorD, bus0.irWrite, bus0.pcWrite,
                   bus0.pcWriteCond, bus0.pcSrc, bus0.aluSrcA, bus0.aluSrcB, bus0.aluOP,
                   bus0.regDst, bus0.memToReg, bus0.regWrite, bus0.illegalOp, bus0.busErr};
  assign obs[1] = {bus1.memRead, bus1.memWrite, bus1.iorD, bus1.irWrite, bus1.pcWrite,
                   bus1.pcWriteCond, bus1.pcSrc, bus1.aluSrcA, bus1.aluSrcB, bus1.aluOP,
                   bus1.regDst, bus1.memToReg, bus1.regWrite, bus1.illegalOp, bus1.busErr};
  assign st_obs[0] = bus0.state;
  assign st_obs[1] = bus1.state;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model
  int    tmo     [2] = '{15, 3};
  int    m_state [2] = '{0, 0};
  int    m_wait  [2] = '{0, 0};
  bit    m_valid     = 1'b0;

  // values seen at the output-check point of the last cycle
  ctrl_t snap   [2];
  int    pre_st [2];

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_tests++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic int dispatch(input logic [5:0] op);
    case (op)
      6'h00:          return 6;
      6'h23, 6'h2B:   return 2;
      6'h04:          return 8;
      6'h02:          return 9;
`ifdef MULTICYCLE_CONTROL_ADDI_EN
      6'h08:          return 10;
`endif
      default:        return 12;
    endcase
  endfunction

  function automatic ctrl_t exp_ctrl(input int s, input logic rdy);
    ctrl_t c = '0;
    case (s)
      0:  begin c.memRead = 1; c.aluSrcB = 2'b01; c.irWrite = rdy; c.pcWrite = rdy; end
      1:  c.aluSrcB = 2'b11;
      2:  begin c.aluSrcA = 1; c.aluSrcB = 2'b10; end
      3:  begin c.memRead = 1; c.iorD = 1; end
      4:  begin c.regWrite = 1; c.memToReg = 1; end
      5:  begin c.memWrite = 1; c.iorD = 1; end
      6:  begin c.aluSrcA = 1; c.aluOP = 2'b10; end
      7:  begin c.regDst = 1; c.regWrite = 1; end
      8:  begin c.aluSrcA = 1; c.aluOP = 2'b01; c.pcWriteCond = 1; c.pcSrc = 2'b01; end
      9:  begin c.pcWrite = 1; c.pcSrc = 2'b10; end
      10: begin c.aluSrcA = 1; c.aluSrcB = 2'b10; end
      11: c.regWrite = 1;
      12: c.illegalOp = 1;
      13: c.busErr = 1;
      default: ;
    endcase
    return c;
  endfunction

  // One clock edge of the model. Wait states count low-ready cycles of the
  // current access; the access fails once the count reaches the timeout.
  function automatic void model_step(input int i);
    int s = m_state[i];
    if (rst) begin
      m_state[i] = 0;
      m_wait[i]  = 0;
      return;
    end
    case (s)
      0, 3, 5: begin
        if (rdy_d[i]) begin
          m_wait[i]  = 0;
          m_state[i] = (s == 0) ? 1 : (s == 3) ? 4 : 0;
        end else begin
          m_wait[i]++;
          if (m_wait[i] == tmo[i]) begin
            m_wait[i]  = 0;
            m_state[i] = 13;
          end
        end
      end
      1:       m_state[i] = dispatch(op_d[i]);
      2:       m_state[i] = (op_d[i] == 6'h23) ? 3 : 5;
      6:       m_state[i] = 7;
      10:      m_state[i] = 11;
      default: m_state[i] = 0;
    endcase
  endfunction

  task automatic cyc2(input logic [5:0] o0, input logic r0, input logic [5:0] o1, input logic r1);
    op_d[0] = o0; rdy_d[0] = r0;
    op_d[1] = o1; rdy_d[1] = r1;
    #1;
    for (int i = 0; i < 2; i++) begin
      if (m_valid) check($sformatf("ctrl%0d_s%0d", i, m_state[i]), 32'(obs[i]),
                         32'(exp_ctrl(m_state[i], rdy_d[i])));
      snap[i]   = obs[i];
      pre_st[i] = int'(st_obs[i]);
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_step(i);
    if (rst) m_valid = 1'b1;
    #1;
    for (int i = 0; i < 2; i++)
      if (m_valid) check($sformatf("state%0d", i), 32'(st_obs[i]), 32'(m_state[i]));
  endtask

  task automatic cyc(input logic [5:0] o, input logic r);
    cyc2(o, r, o, r);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(6'h00, 1'b0);
    rst = 1'b0;
    check("rst_state0", 32'(st_obs[0]), 0);
    check("rst_state1", 32'(st_obs[1]), 0);
    check("rst_nofault", {28'd0, bus0.busErr, bus0.illegalOp, bus1.busErr, bus1.illegalOp}, 0);
  endtask

  task automatic run_lat(input logic [5:0] op, input int expected);
    int n = 0;
    do begin
      cyc(op, 1'b1);
      n++;
    end while (st_obs[0] != 4'd0 && n < 20);
    check($sformatf("latency_op%02h", op), n, expected);
  endtask

  logic [5:0] lat_op  [6] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};
`ifdef MULTICYCLE_CONTROL_ADDI_EN
  int         lat_exp [6] = '{4, 5, 4, 3, 3, 4};
  localparam int ADDI_STATE = 10;
`else
  int         lat_exp [6] = '{4, 5, 4, 3, 3, 3};
  localparam int ADDI_STATE = 12;
`endif

  initial begin
    int n, n_mw, n_be, k;
    int run_left [2];
    logic [5:0] rop [2];
    logic       rrdy [2];
    logic [5:0] op_pool [6];

    op_d[0] = '0; op_d[1] = '0; rdy_d[0] = 1'b0; rdy_d[1] = 1'b0;

    // reset state; FETCH outputs with memReady low then high
    do_reset();
    cyc(6'h23, 1'b0);
    check("fetch_wait_ctrl", 32'(snap[0]), 32'(ctrl_t'(18'b1_0_0_0_0_0_00_0_01_00_0_0_0_0_0)));

    // lw with memReady high: 0,1,2,3,4,0 and regWrite only in MEMWB
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cyc(6'h23, 1'b1);
      check($sformatf("lw_seq%0d", i), pre_st[0], i);
      check($sformatf("lw_regwr%0d", i), 32'(snap[0].regWrite), (i == 4) ? 1 : 0);
    end
    check("lw_seq_end", 32'(st_obs[0]), 0);

    // per-class latencies with memReady high
    do_reset();
    for (int i = 0; i < 6; i++) run_lat(lat_op[i], lat_exp[i]);

    // sw with 5 wait cycles in MEMWR on instance 0
    do_reset();
    for (int i = 0; i < 3; i++) cyc(6'h2B, 1'b1);
    check("sw_in_memwr", 32'(st_obs[0]), 5);
    n_mw = 0; n_be = 0;
    for (int i = 0; i < 6; i++) begin
      cyc2(6'h2B, (i == 5), 6'h2B, 1'b1);
      n_mw += int'(snap[0].memWrite);
      n_be += int'(snap[0].busErr);
    end
    check("sw_memwrite_cycles", n_mw, 6);
    check("sw_no_buserr", n_be, 0);
    check("sw_back_fetch", 32'(st_obs[0]), 0);

    // timeout on instance 1 (TIMEOUT_CYC=3) in MEMRD
    do_reset();
    for (int i = 0; i < 3; i++) cyc(6'h23, 1'b1);
    check("to_in_memrd", 32'(st_obs[1]), 3);
    n = 0; k = 0;
    do begin
      cyc2(6'h23, 1'b1, 6'h23, 1'b0);
      if (pre_st[1] == 3) n++;
      k++;
    end while (st_obs[1] == 4'd3 && k < 10);
    check("to_memrd_cycles", n, 3);
    check("to_buserr_state", 32'(st_obs[1]), 13);
    cyc2(6'h23, 1'b1, 6'h23, 1'b0);
    check("to_buserr_pulse", 32'(snap[1].busErr), 1);
    check("to_return", 32'(st_obs[1]), 0);
    cyc2(6'h23, 1'b1, 6'h23, 1'b0);
    check("to_pulse_single", 32'(snap[1].busErr), 0);

    // ready in the timeout cycle completes the read
    do_reset();
    for (int i = 0; i < 3; i++) cyc(6'h23, 1'b1);
    cyc2(6'h23, 1'b1, 6'h23, 1'b0);
    cyc2(6'h23, 1'b1, 6'h23, 1'b0);
    cyc2(6'h23, 1'b1, 6'h23, 1'b1);
    check("ready_wins_state", 32'(st_obs[1]), 4);

    // illegal opcode and addi dispatch
    do_reset();
    cyc(6'h3F, 1'b1);
    cyc(6'h3F, 1'b1);
    check("illegal_state", 32'(st_obs[0]), 12);
    cyc(6'h3F, 1'b1);
    check("illegal_pulse", 32'(snap[0].illegalOp), 1);
    check("illegal_return", 32'(st_obs[0]), 0);
    do_reset();
    cyc(6'h08, 1'b1);
    cyc(6'h08, 1'b1);
    check("addi_dispatch", 32'(st_obs[0]), ADDI_STATE);

    // reset in the middle of a MEMWR wait; counter must restart
    do_reset();
    for (int i = 0; i < 3; i++) cyc(6'h2B, 1'b1);
    cyc(6'h2B, 1'b0);
    cyc(6'h2B, 1'b0);
    rst = 1'b1;
    cyc(6'h2B, 1'b0);
    rst = 1'b0;
    check("midrst_state", 32'(st_obs[0]), 0);
    for (int i = 0; i < 14; i++) begin
      cyc(6'h2B, 1'b0);
      if (i == 0) check("midrst_memwrite", 32'(snap[0].memWrite), 0);
    end
    check("midrst_fetch_hold", 32'(st_obs[0]), 0);
    cyc(6'h2B, 1'b1);
    check("midrst_fetch_done", 32'(st_obs[0]), 1);

    // randomized phase against the model
    op_pool = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};
    do_reset();
    run_left = '{0, 0};
    rop[0] = 6'h00; rop[1] = 6'h00;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (m_state[i] == 0)
          rop[i] = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63))
                                               : op_pool[$urandom_range(0, 5)];
        if (run_left[i] > 0) begin
          rrdy[i] = 1'b0;
          run_left[i]--;
        end else if ($urandom_range(0, 29) == 0) begin
          rrdy[i]     = 1'b0;
          run_left[i] = $urandom_range(2, 18);
        end else begin
          rrdy[i] = ($urandom_range(0, 3) != 0);
        end
      end
      rst = ($urandom_range(0, 249) == 0);
      cyc2(rop[0], rrdy[0], rop[1], rrdy[1]);
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
